// File: rtl/crc_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : crc_frame_ctrl
//  Purpose  : Frame-level controller for an 8-bit bit-serial CRC engine.
//             Buffers a whole frame received over a valid/ready byte
//             handshake. It then reseeds the engine and streams the frame
//             LSB-first with no gaps in eng_active. Finally it collects the
//             8 serial CRC bits into a byte, and gives up after a bounded
//             wait for the engine to respond.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             start, frame_len   - frame request and byte count (IDLE only)
//             din, din_valid,
//             din_ready          - byte input handshake
//             busy               - high whenever not IDLE
//             eng_rst, eng_data,
//             eng_active         - drive the engine's reset / data / frame
//             eng_crc, eng_valid - serial CRC returned by the engine
//             crc_out, crc_valid - completed CRC byte and its update pulse
//             err                - pulse when the engine fails to respond
//  Revision : 1.0 - initial release
// ============================================================================
module crc_frame_ctrl #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             busy,
    output logic             eng_rst,
    output logic             eng_data,
    output logic             eng_active,
    input  logic             eng_crc,
    input  logic             eng_valid,
    output logic [7:0]       crc_out,
    output logic             crc_valid,
    output logic             err
);

    localparam int c_DEPTH = 1 << LEN_W;
    localparam int c_TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEED    = 3'd2,
        S_STREAM  = 3'd3,
        S_COLLECT = 3'd4
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_wptr;
    logic [LEN_W-1:0] r_byte;     // byte currently on eng_data
    logic [2:0]       r_bit;      // bit currently on eng_data
    logic [2:0]       r_rx_cnt;   // CRC bits received so far
    logic [7:0]       r_crc_sr;
    logic [c_TW-1:0]  r_tcnt;
    logic [7:0]       r_buf [c_DEPTH];

    logic [LEN_W-1:0] w_len_m1;
    logic             w_last_bit;
    logic [LEN_W-1:0] w_next_byte;
    logic [2:0]       w_next_bit;
    logic [7:0]       w_sr_next;
    logic [c_TW-1:0]  w_tcnt_next;

    assign w_len_m1    = r_len - LEN_W'(1);
    assign w_last_bit  = (r_byte == w_len_m1) && (r_bit == 3'd7);
    assign w_next_bit  = r_bit + 3'd1;
    assign w_next_byte = (r_bit == 3'd7) ? r_byte + LEN_W'(1) : r_byte;
    // First received CRC bit ends up in bit 0 after eight shifts.
    assign w_sr_next   = {eng_crc, r_crc_sr[7:1]};
    assign w_tcnt_next = r_tcnt + c_TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_wptr     <= '0;
            r_byte     <= '0;
            r_bit      <= '0;
            r_rx_cnt   <= '0;
            r_crc_sr   <= '0;
            r_tcnt     <= '0;
            din_ready  <= 1'b0;
            busy       <= 1'b0;
            eng_rst    <= 1'b1;     // keep the engine in reset with us
            eng_data   <= 1'b0;
            eng_active <= 1'b0;
            crc_out    <= 8'h00;
            crc_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            eng_rst   <= 1'b0;
            crc_valid <= 1'b0;
            err       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start && (frame_len != '0)) begin
                        r_len     <= frame_len;
                        r_wptr    <= '0;
                        busy      <= 1'b1;
                        din_ready <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // din_ready is high for the whole of LOAD, so din_valid
                    // alone marks a handshake here.
                    if (din_valid) begin
                        r_buf[r_wptr] <= din;
                        r_wptr        <= r_wptr + LEN_W'(1);
                        if (r_wptr == w_len_m1) begin
                            din_ready <= 1'b0;
                            eng_rst   <= 1'b1;
                            r_state   <= S_SEED;
                        end
                    end
                end

                S_SEED: begin
                    // Present the first bit together with eng_active so the
                    // stream starts with no bubble.
                    r_byte     <= '0;
                    r_bit      <= '0;
                    eng_active <= 1'b1;
                    eng_data   <= r_buf[0][0];
                    r_state    <= S_STREAM;
                end

                S_STREAM: begin
                    if (w_last_bit) begin
                        eng_active <= 1'b0;
                        eng_data   <= 1'b0;
                        r_tcnt     <= '0;
                        r_rx_cnt   <= '0;
                        r_state    <= S_COLLECT;
                    end else begin
                        r_byte   <= w_next_byte;
                        r_bit    <= w_next_bit;
                        eng_data <= r_buf[w_next_byte][w_next_bit];
                    end
                end

                S_COLLECT: begin
                    r_tcnt <= w_tcnt_next;
                    // A completing eighth bit wins over a timeout in the
                    // same cycle.
                    if (eng_valid && (r_rx_cnt == 3'd7)) begin
                        r_crc_sr  <= w_sr_next;
                        crc_out   <= w_sr_next;
                        crc_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        if (eng_valid) begin
                            r_crc_sr <= w_sr_next;
                            r_rx_cnt <= r_rx_cnt + 3'd1;
                        end
                        if (w_tcnt_next == c_TW'(TIMEOUT)) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    busy       <= 1'b0;
                    din_ready  <= 1'b0;
                    eng_active <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_frame_ctrl
//  Purpose  : Directed self-checking bench for crc_frame_ctrl with a
//             behavioural bit-serial CRC engine (seed 0xD8, taps 0x44,
//             LSB-first in and out) attached to the engine ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc_frame_ctrl;

    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic [7:0]       din;
    logic             din_valid;
    logic             din_ready;
    logic             busy;
    logic             eng_rst;
    logic             eng_data;
    logic             eng_active;
    logic             eng_crc;
    logic             eng_valid;
    logic [7:0]       crc_out;
    logic             crc_valid;
    logic             err;

    crc_frame_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_len  (frame_len),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .busy       (busy),
        .eng_rst    (eng_rst),
        .eng_data   (eng_data),
        .eng_active (eng_active),
        .eng_crc    (eng_crc),
        .eng_valid  (eng_valid),
        .crc_out    (crc_out),
        .crc_valid  (crc_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
        logic fb;
        fb = c[0] ^ d;
        return {fb, c[7:1]} ^ (fb ? 8'h44 : 8'h00);
    endfunction

    // ---------------- behavioural engine ----------------
    logic       mute = 1'b0;     // when set the engine never raises Valid
    logic [7:0] m_crc  = 8'h00;
    logic       m_was  = 1'b0;
    logic [3:0] m_left = 4'd0;
    int         m_run = 0, m_last_run = 0, m_runs = 0, m_seeds = 0;
    logic       m_bits [$];

    always @(posedge clk) begin
        if (eng_rst) begin
            m_crc  <= 8'hD8;
            m_was  <= 1'b0;
            m_left <= 4'd0;
        end else if (eng_active) begin
            m_crc <= crc_step(m_crc, eng_data);
            m_was <= 1'b1;
        end else if (m_was) begin
            m_was  <= 1'b0;
            m_left <= 4'd8;
        end else if (m_left != 4'd0) begin
            m_crc  <= {1'b0, m_crc[7:1]};
            m_left <= m_left - 4'd1;
        end
    end

    assign eng_valid = (m_left != 4'd0) && !mute;
    assign eng_crc   = m_crc[0];

    // Activity bookkeeping: length of each contiguous eng_active run,
    // bits seen on eng_data, and eng_rst cycles.
    always @(posedge clk) begin
        if (eng_active) begin
            m_run <= m_run + 1;
            m_bits.push_back(eng_data);
        end else if (m_run != 0) begin
            m_last_run <= m_run;
            m_runs     <= m_runs + 1;
            m_run      <= 0;
        end
        if (eng_rst) m_seeds <= m_seeds + 1;
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] tx [16];

    task automatic do_start(input int n);
        start = 1'b1;
        frame_len = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        frame_len = '0;
        chk("start_busy", busy, 1);
        chk("start_din_ready", din_ready, 1);
    endtask

    task automatic load_frame(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            int w;
            gap = $urandom_range(0, 2);
            din_valid = 1'b0;
            repeat (gap) @(negedge clk);
            din = tx[i];
            din_valid = 1'b1;
            w = 0;
            while (!din_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("load_ready", din_ready, 1);
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(crc_valid || err) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(crc_valid), 1);
    endtask

    logic [7:0] exp_crc;
    int         runs0, seeds0, mism, n;

    initial begin
        rst = 1'b1; start = 1'b0; frame_len = '0; din = 8'h00; din_valid = 1'b0;
        for (int i = 0; i < 16; i++) tx[i] = 8'h00;

        // ---- reset ----
        repeat (2) @(negedge clk);
        chk("rst_eng_rst", eng_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_eng_active", eng_active, 0);
        chk("rst_eng_data", eng_data, 0);
        chk("rst_crc_out", crc_out, 8'h00);
        chk("rst_crc_valid", crc_valid, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_eng_rst", eng_rst, 0);

        // ---- START with zero length is ignored ----
        start = 1'b1; frame_len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_len_busy", busy, 0);
        chk("zero_len_ready", din_ready, 0);

        // ---- single byte 0x00 ----
        tx[0] = 8'h00;
        runs0 = m_runs; seeds0 = m_seeds; m_bits.delete();
        do_start(1);
        load_frame(1);
        chk("seed_eng_rst", eng_rst, 1);
        chk("seed_no_active", eng_active, 0);
        @(negedge clk);
        chk("first_active", eng_active, 1);
        wait_done("single_done");
        chk("single_crc", crc_out, 8'h14);
        chk("single_busy_low", busy, 0);
        chk("single_run_len", m_last_run, 8);
        chk("single_runs", m_runs - runs0, 1);
        chk("single_seeds", m_seeds - seeds0, 1);
        mism = 0;
        foreach (m_bits[i]) if (m_bits[i] !== 1'b0) mism++;
        chk("single_bits_n", m_bits.size(), 8);
        chk("single_bits_zero", mism, 0);
        @(negedge clk);
        chk("single_pulse_once", crc_valid, 0);

        // ---- 15-byte frame with DIN_VALID gaps ----
        tx = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
               8'hFF, 8'h80, 8'h7E, 8'h00, 8'h5A, 8'hC3, 8'h96, 8'h00};
        exp_crc = 8'hD8;
        for (int b = 0; b < 15; b++)
            for (int k = 0; k < 8; k++) exp_crc = crc_step(exp_crc, tx[b][k]);
        runs0 = m_runs; seeds0 = m_seeds; m_bits.delete();
        do_start(15);
        load_frame(15);
        wait_done("long_done");
        chk("long_crc", crc_out, exp_crc);
        chk("long_run_len", m_last_run, 120);
        chk("long_runs", m_runs - runs0, 1);
        chk("long_seeds", m_seeds - seeds0, 1);
        chk("long_bits_n", m_bits.size(), 120);
        mism = 0;
        for (int i = 0; i < 120 && i < m_bits.size(); i++)
            if (m_bits[i] !== tx[i / 8][i % 8]) mism++;
        chk("long_bit_order", mism, 0);

        // ---- back-to-back: START in the CRC_VALID cycle ----
        tx[0] = 8'h00;
        seeds0 = m_seeds;
        do_start(1);
        load_frame(1);
        wait_done("b2b_done");
        chk("b2b_crc_reseed", crc_out, 8'h14);
        chk("b2b_seeds", m_seeds - seeds0, 1);

        // ---- timeout: engine never answers ----
        mute = 1'b1;
        tx[0] = 8'h5A;
        do_start(1);
        load_frame(1);
        n = 0;
        while (!eng_active && n < 20) begin @(negedge clk); n++; end
        chk("to_active", eng_active, 1);
        n = 0;
        while (eng_active && n < 20) begin @(negedge clk); n++; end
        chk("to_collect", eng_active, 0);
        n = 0;
        while (!err && n < 40) begin @(negedge clk); n++; end
        chk("to_err_delay", n, TIMEOUT);
        chk("to_err", err, 1);
        chk("to_no_crc_valid", crc_valid, 0);
        chk("to_crc_held", crc_out, 8'h14);
        chk("to_busy_low", busy, 0);
        @(negedge clk);
        chk("to_err_once", err, 0);
        mute = 1'b0;

        // ---- RST mid-STREAM ----
        tx[0] = 8'hFF; tx[1] = 8'h0F;
        do_start(2);
        load_frame(2);
        repeat (3) @(negedge clk);
        chk("abort_streaming", eng_active, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_active", eng_active, 0);
        chk("abort_eng_rst", eng_rst, 1);
        chk("abort_ready", din_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_eng_rst_rel", eng_rst, 0);

        // ---- recovery after abort ----
        tx[0] = 8'h00;
        do_start(1);
        load_frame(1);
        wait_done("recover_done");
        chk("recover_crc", crc_out, 8'h14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
